seq_divider: RTL

//   Multi-cycle signed 32-bit non-restoring divider. It produces the 64-bit div_out that feeds the ALU's div result slot (opcode 5'b10000).

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 21 ++
 rtl/seq_divider_sign_fix.sv | 17 +
 rtl/seq_divider.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state codes and the ALU opcode it serves.
// The optional DIV_DBZ_FLAG_EN build adds a divide-by-zero flag and a one-edge fast path.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    localparam logic [4:0] ALU_OP_DIV = 5'b10000;

endpackage

// File: rtl/seq_divider_if.sv
// Handshake bundle between the control unit (master) and the divider (slave).
// div_by_zero exists only when DIV_DBZ_FLAG_EN is defined.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
`ifdef DIV_DBZ_FLAG_EN
    logic                   div_by_zero;

    modport master (output start, dividend, divisor, input busy, done, result, div_by_zero);
    modport slave  (input start, dividend, divisor, output busy, done, result, div_by_zero);
`else
    modport master (output start, dividend, divisor, input busy, done, result);
    modport slave  (input start, dividend, divisor, output busy, done, result);
`endif
endinterface

// File: rtl/seq_divider_sign_fix.sv
// Combinational conditional two's-complement negate of a quotient/remainder pair.
// Also used to take absolute values of the operands at accept time.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] r_in,
    input  logic             sign_q,
    input  logic             sign_r,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out
);

    assign q_out = sign_q ? (~q_in + {{(WIDTH-1){1'b0}}, 1'b1}) : q_in;
    assign r_out = sign_r ? (~r_in + {{(WIDTH-1){1'b0}}, 1'b1}) : r_in;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed non-restoring divider producing {remainder, quotient}.
// Build option DIV_DBZ_FLAG_EN: exposes div_by_zero and finishes a zero-divisor op on the accept edge.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e           state_r, state_s;
    logic [WIDTH:0]       rem_r;
    logic [WIDTH-1:0]     quo_r, dvs_r;
    logic [CW-1:0]        cnt_r;
    logic                 sign_q_r, sign_r_r, dvs_zero_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 busy_r, done_r, dbz_r;

    logic                 accept_s, dvs_zero_s, fast_s;
    logic [WIDTH-1:0]     dvd_abs_s, dvs_abs_s;
    logic [WIDTH:0]       shift_s, step_s;
    logic [WIDTH-1:0]     rem_fix_s, q_sgn_s, r_sgn_s;

    assign accept_s   = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign dvs_zero_s = (bus.divisor == {WIDTH{1'b0}});
`ifdef DIV_DBZ_FLAG_EN
    assign fast_s     = dvs_zero_s;
`else
    assign fast_s     = 1'b0;
`endif

    div_sign_fix #(.WIDTH(WIDTH)) u_abs (
        .q_in   (bus.dividend),
        .r_in   (bus.divisor),
        .sign_q (bus.dividend[WIDTH-1]),
        .sign_r (bus.divisor[WIDTH-1]),
        .q_out  (dvd_abs_s),
        .r_out  (dvs_abs_s)
    );

    assign shift_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    assign step_s  = rem_r[WIDTH] ? (shift_s + {1'b0, dvs_r}) : (shift_s - {1'b0, dvs_r});
    // Restored remainder lies in [0, divisor), so WIDTH bits of the sum are exact.
    assign rem_fix_s = rem_r[WIDTH] ? (rem_r[WIDTH-1:0] + dvs_r) : rem_r[WIDTH-1:0];

    div_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .q_in   (quo_r),
        .r_in   (rem_fix_s),
        .sign_q (sign_q_r),
        .sign_r (sign_r_r),
        .q_out  (q_sgn_s),
        .r_out  (r_sgn_s)
    );

    // Next-state logic for the IDLE/ITER/FIX/DONE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = fast_s ? ST_DONE : ST_ITER;
                else          state_s = ST_IDLE;
            end
            ST_ITER: begin
                if (cnt_r == CW'(WIDTH - 1)) state_s = ST_FIX;
                else                         state_s = ST_ITER;
            end
            ST_FIX:  state_s = ST_DONE;
            ST_DONE: begin
                if (accept_s) state_s = fast_s ? ST_DONE : ST_ITER;
                else          state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_ITER) || (state_s == ST_FIX);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Datapath: operand capture, one non-restoring step per ITER cycle, signed result write in FIX.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            dvs_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            sign_q_r   <= 1'b0;
            sign_r_r   <= 1'b0;
            dvs_zero_r <= 1'b0;
            dbz_r      <= 1'b0;
            result_r   <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= dvd_abs_s;
            dvs_r      <= dvs_abs_s;
            cnt_r      <= {CW{1'b0}};
            sign_q_r   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r_r   <= bus.dividend[WIDTH-1];
            dvs_zero_r <= dvs_zero_s;
            dbz_r      <= fast_s;
            if (fast_s) result_r <= {bus.dividend, {WIDTH{1'b1}}};
            else        result_r <= result_r;
        end else if (state_r == ST_ITER) begin
            rem_r <= step_s;
            quo_r <= {quo_r[WIDTH-2:0], ~step_s[WIDTH]};
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else if (state_r == ST_FIX) begin
            // With a zero divisor every step subtracts nothing, so the remainder is |dividend|
            // and the sign fix restores the original dividend; only the quotient needs forcing.
            if (dvs_zero_r) result_r <= {r_sgn_s, {WIDTH{1'b1}}};
            else            result_r <= {r_sgn_s, q_sgn_s};
        end else begin
            result_r <= result_r;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
`ifdef DIV_DBZ_FLAG_EN
    assign bus.div_by_zero = dbz_r;
`else
    logic unused_dbz_s;
    assign unused_dbz_s = dbz_r;
`endif

endmodule
